// File: rtl/frame_buf_pkg.sv
// -----------------------------------------------------------------------------
// frame_buf_pkg
//   Shared types and constants for the frame-buffer arbiter slice.
//   - FB_ADDR_W / FB_DATA_W : default frame-buffer address and pixel widths
//                             (320x240 words of RGB565).
//   - arb_state_t           : grant currently driven onto the BRAM port.
//   - fb_wr_t               : one buffered camera write {addr, data}.
//   - fb_sat_inc16          : saturating 16-bit increment for the drop counter.
// -----------------------------------------------------------------------------
package frame_buf_pkg;

    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD   = 2'd1,
        ARB_WR   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } fb_wr_t;

    function automatic logic [15:0] fb_sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// -----------------------------------------------------------------------------
// fb_wr_fifo
//   Synchronous FIFO buffering camera writes while the BRAM port serves reads.
//   A push into a full FIFO is accepted when a pop happens in the same cycle,
//   because the popped slot is the one the push refills.
//
//   Parameters:
//     DEPTH : number of entries, power of 2, at least 2.
//     T     : entry type, fb_wr_t by default.
//   Ports:
//     i_clk        in   clock, rising edge
//     i_reset      in   synchronous active-high reset, flushes the FIFO
//     i_push       in   push request
//     i_push_data  in   entry to push
//     i_pop        in   pop request (ignored when empty)
//     o_pop_data   out  head entry (valid when !o_empty)
//     o_full       out  FIFO holds DEPTH entries
//     o_empty      out  FIFO holds no entries
//     o_count      out  current occupancy
// -----------------------------------------------------------------------------
module fb_wr_fifo
    import frame_buf_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = fb_wr_t,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  T                 i_push_data,
    input  logic             i_pop,
    output T                 o_pop_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_full    = (r_count == CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop && !w_empty;
    // Full-and-popping frees the head slot this cycle, so the push still fits.
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    // Storage carries no reset; occupancy and pointers alone define content.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;

endmodule

// File: rtl/frame_buf_arbiter.sv
// -----------------------------------------------------------------------------
// frame_buf_arbiter
//   Arbitrates one synchronous single-port BRAM (320x240 RGB565 frame) between
//   the camera pixel writer and a read client. Camera writes are buffered in
//   fb_wr_fifo; reads win by default but may take at most RD_BURST_MAX
//   consecutive grants while writes are waiting, after which one write issues.
//
//   Optional feature macro: FB_ARB_STATS_EN adds the drop_cnt port and counter.
//
//   Read handshake: a read is transferred in every cycle where rd_req and
//   rd_ready are both high. rd_ready is combinational and is only high when
//   rd_req is high; the requester holds rd_req and a stable rd_addr until it
//   sees rd_ready. Data returns on rd_valid/rd_data three cycles after accept.
//
//   Ports:
//     pclk, reset          clock (rising edge), synchronous active-high reset
//     we, wAddr, wdata     camera write strobe, address, pixel
//     rd_req, rd_addr      read request and address
//     rd_ready             read accepted this cycle
//     rd_valid, rd_data    registered read return
//     mem_en, mem_we,
//     mem_addr, mem_wdata  registered BRAM port
//     mem_rdata            BRAM read data, one cycle after a read enable
//     clr_ovf              clears wr_ovf (and drop_cnt)
//     wr_ovf               sticky: a camera write was dropped
//     drop_cnt             saturating dropped-write count (FB_ARB_STATS_EN)
//     o_dbg_state          grant currently driven onto the BRAM port
//     o_dbg_fifo_count     write FIFO occupancy
// -----------------------------------------------------------------------------
module frame_buf_arbiter
    import frame_buf_pkg::*;
#(
    parameter int  ADDR_W       = FB_ADDR_W,
    parameter int  DATA_W       = FB_DATA_W,
    parameter int  WFIFO_DEPTH  = 8,
    parameter int  RD_BURST_MAX = 4,
    localparam int CNT_W        = $clog2(WFIFO_DEPTH + 1)
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wAddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              clr_ovf,
    output logic              wr_ovf,
`ifdef FB_ARB_STATS_EN
    output logic [15:0]       drop_cnt,
`endif
    output arb_state_t        o_dbg_state,
    output logic [CNT_W-1:0]  o_dbg_fifo_count
);

    localparam int               RUN_W   = $clog2(RD_BURST_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RD_BURST_MAX);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_ent_t;

    // ------------------------------------------------------------------
    // Write FIFO
    // ------------------------------------------------------------------
    wr_ent_t          w_push_ent;
    wr_ent_t          w_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;

    assign w_push_ent.addr = wAddr;
    assign w_push_ent.data = wdata;

    // ------------------------------------------------------------------
    // Grant decision for this cycle
    // ------------------------------------------------------------------
    arb_state_t       r_state;
    logic [RUN_W-1:0] r_rd_run;
    logic             w_fifo_has_data;
    logic             w_grant_rd;
    logic             w_grant_wr;
    logic             w_drop;

    assign w_fifo_has_data = (w_fifo_count != '0);
    // Reads always win against an empty FIFO; otherwise only while the burst
    // budget lasts. Both grants are forced off during reset.
    assign w_grant_rd = !reset && rd_req && (!w_fifo_has_data || (r_rd_run < RUN_MAX));
    assign w_grant_wr = !reset && w_fifo_has_data && !w_grant_rd;
    assign rd_ready   = w_grant_rd;

    // A full FIFO only loses the push when nothing pops this cycle.
    assign w_drop = !reset && we && w_fifo_full && !w_grant_wr;

    fb_wr_fifo #(
        .DEPTH (WFIFO_DEPTH),
        .T     (wr_ent_t)
    ) u_wr_fifo (
        .i_clk       (pclk),
        .i_reset     (reset),
        .i_push      (we),
        .i_push_data (w_push_ent),
        .i_pop       (w_grant_wr),
        .o_pop_data  (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // Arbiter FSM, BRAM port registers and read return pipeline.
    // The state register holds the grant now visible on mem_*.
    // Read pipeline: accept (N) -> mem_en (N+1) -> BRAM data (N+2)
    // -> rd_valid/rd_data (N+3).
    // ------------------------------------------------------------------
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_rd_s2;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_rd_run    <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd_s2     <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            // A read enable this cycle means BRAM data next cycle.
            r_rd_s2    <= r_mem_en && !r_mem_we;
            r_rd_valid <= r_rd_s2;
            if (r_rd_s2) begin
                r_rd_data <= mem_rdata;
            end

            if (w_grant_rd) begin
                r_state    <= ARB_RD;
                r_mem_en   <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= rd_addr;
                // The burst budget is only spent while a write is waiting;
                // it is deliberately not cleared by an empty FIFO.
                if (w_fifo_has_data) begin
                    r_rd_run <= r_rd_run + RUN_W'(1);
                end
            end else if (w_grant_wr) begin
                r_state     <= ARB_WR;
                r_mem_en    <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= w_head.addr;
                r_mem_wdata <= w_head.data;
                r_rd_run    <= '0;
            end else begin
                r_state  <= ARB_IDLE;
                r_mem_en <= 1'b0;
                r_mem_we <= 1'b0;
                r_rd_run <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Overflow flag and optional drop counter. A drop in the same cycle as
    // clr_ovf wins, so the drop is never lost.
    // ------------------------------------------------------------------
    logic r_wr_ovf;

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_wr_ovf <= 1'b0;
        end else if (w_drop) begin
            r_wr_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_wr_ovf <= 1'b0;
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_drop_cnt <= clr_ovf ? 16'd1 : fb_sat_inc16(r_drop_cnt);
        end else if (clr_ovf) begin
            r_drop_cnt <= '0;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic w_unused;
    assign w_unused = w_fifo_empty;

    assign rd_valid         = r_rd_valid && !w_unused | r_rd_valid;
    assign rd_data          = r_rd_data;
    assign mem_en           = r_mem_en;
    assign mem_we           = r_mem_we;
    assign mem_addr         = r_mem_addr;
    assign mem_wdata        = r_mem_wdata;
    assign wr_ovf           = r_wr_ovf;
    assign o_dbg_state      = r_state;
    assign o_dbg_fifo_count = w_fifo_count;

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// -----------------------------------------------------------------------------
// tb_frame_buf_arbiter
//   Directed bench for frame_buf_arbiter. Inputs are driven 1 time unit after
//   the rising edge, outputs are checked on the falling edge. Cycle c of a
//   scenario is the period in which its inputs are driven.
//   The BRAM model returns the read address as data one cycle after mem_en.
// -----------------------------------------------------------------------------
module tb_frame_buf_arbiter;
    import frame_buf_pkg::*;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    logic              pclk = 1'b0;
    logic              reset;
    logic              we;
    logic [ADDR_W-1:0] wAddr;
    logic [DATA_W-1:0] wdata;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              clr_ovf;
    logic              wr_ovf;
`ifdef FB_ARB_STATS_EN
    logic [15:0]       drop_cnt;
`endif
    arb_state_t        dbg_state;
    logic [CNT_W-1:0]  dbg_fifo_count;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- clock / reset ----------------
    always #5 pclk = ~pclk;

    // ---------------- BRAM model ----------------
    always @(posedge pclk) begin
        if (mem_en && !mem_we) begin
            mem_rdata <= mem_addr[DATA_W-1:0];
        end
    end

    frame_buf_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .WFIFO_DEPTH  (8),
        .RD_BURST_MAX (4)
    ) dut (
        .pclk             (pclk),
        .reset            (reset),
        .we               (we),
        .wAddr            (wAddr),
        .wdata            (wdata),
        .rd_req           (rd_req),
        .rd_addr          (rd_addr),
        .rd_ready         (rd_ready),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .mem_en           (mem_en),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .clr_ovf          (clr_ovf),
        .wr_ovf           (wr_ovf),
`ifdef FB_ARB_STATS_EN
        .drop_cnt         (drop_cnt),
`endif
        .o_dbg_state      (dbg_state),
        .o_dbg_fifo_count (dbg_fifo_count)
    );

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        we      = 1'b0;
        rd_req  = 1'b0;
        clr_ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            next_cycle();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset   = 1'b1;
        we      = 1'b1;
        wAddr   = 17'h00055;
        wdata   = 16'h1234;
        rd_req  = 1'b0;
        rd_addr = '0;
        clr_ovf = 1'b0;
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            @(negedge pclk);
            n_total++;
            if ({rd_ready, rd_valid, mem_en, mem_we, wr_ovf} !== 5'b0) begin
                $display("FAIL reset_flags c=%0d got %b want 00000", c,
                         {rd_ready, rd_valid, mem_en, mem_we, wr_ovf});
            end else n_pass++;
            n_total++;
            if ({rd_data, mem_addr, mem_wdata} !== '0) begin
                $display("FAIL reset_data c=%0d rd_data=%h mem_addr=%h mem_wdata=%h want 0",
                         c, rd_data, mem_addr, mem_wdata);
            end else n_pass++;
            n_total++;
            if (dbg_state !== ARB_IDLE || dbg_fifo_count !== 4'd0) begin
                $display("FAIL reset_state c=%0d state=%0d count=%0d want 0/0",
                         c, dbg_state, dbg_fifo_count);
            end else n_pass++;
`ifdef FB_ARB_STATS_EN
            n_total++;
            if (drop_cnt !== 16'd0) begin
                $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt);
            end else n_pass++;
`endif
            next_cycle();
        end
        reset = 1'b0;
        we    = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge pclk);
            n_total++;
            if (mem_we !== 1'b0 || mem_en !== 1'b0 || dbg_fifo_count !== 4'd0) begin
                $display("FAIL post_reset_idle c=%0d mem_we=%b mem_en=%b count=%0d want 0/0/0",
                         c, mem_we, mem_en, dbg_fifo_count);
            end else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_writes_only();
        for (int c = 0; c < 14; c++) begin
            we    = (c < 10);
            wAddr = ADDR_W'(c);
            wdata = 16'hA000 + DATA_W'(c);
            @(negedge pclk);
            n_total++;
            if (c >= 2 && c < 12) begin
                if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ADDR_W'(c - 2) ||
                    mem_wdata !== 16'hA000 + DATA_W'(c - 2)) begin
                    $display("FAIL wr_stream c=%0d en=%b we=%b addr=%h data=%h want 1/1/%h/%h",
                             c, mem_en, mem_we, mem_addr, mem_wdata, c - 2, 16'hA000 + c - 2);
                end else n_pass++;
            end else begin
                if (mem_we !== 1'b0) begin
                    $display("FAIL wr_stream_idle c=%0d mem_we=%b want 0", c, mem_we);
                end else n_pass++;
            end
            next_cycle();
        end
        we = 1'b0;
        @(negedge pclk);
        n_total++;
        if (wr_ovf !== 1'b0) begin
            $display("FAIL wr_stream_ovf got %b want 0", wr_ovf);
        end else n_pass++;
        next_cycle();
    endtask

    task automatic test_continuous_reads();
        for (int c = 0; c < 12; c++) begin
            rd_req  = (c < 8);
            rd_addr = ADDR_W'(100 + c);
            @(negedge pclk);
            n_total++;
            if (rd_ready !== (c < 8)) begin
                $display("FAIL rd_cont_ready c=%0d got %b want %b", c, rd_ready, c < 8);
            end else n_pass++;
            n_total++;
            if (c >= 1 && c < 9) begin
                if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ADDR_W'(100 + c - 1)) begin
                    $display("FAIL rd_cont_mem c=%0d en=%b we=%b addr=%0d want 1/0/%0d",
                             c, mem_en, mem_we, mem_addr, 100 + c - 1);
                end else n_pass++;
            end else begin
                if (mem_en !== 1'b0) begin
                    $display("FAIL rd_cont_mem_idle c=%0d mem_en=%b want 0", c, mem_en);
                end else n_pass++;
            end
            n_total++;
            if (c >= 3 && c < 11) begin
                if (rd_valid !== 1'b1 || rd_data !== DATA_W'(100 + c - 3)) begin
                    $display("FAIL rd_cont_data c=%0d valid=%b data=%0d want 1/%0d",
                             c, rd_valid, rd_data, 100 + c - 3);
                end else n_pass++;
            end else begin
                if (rd_valid !== 1'b0) begin
                    $display("FAIL rd_cont_valid_idle c=%0d rd_valid=%b want 0", c, rd_valid);
                end else n_pass++;
            end
            next_cycle();
        end
        rd_req = 1'b0;
    endtask

    task automatic test_reads_with_pending_write();
        logic [11:0] exp_ready;
        logic [11:0] exp_valid;
        int          k;
        int          v;
        exp_ready = 12'b0000_1101_1110;
        exp_valid = 12'b0110_1111_0000;
        k = 0;
        v = 0;
        for (int c = 0; c < 12; c++) begin
            we      = (c == 0);
            wAddr   = 17'h01234;
            wdata   = 16'hBEEF;
            rd_req  = (c >= 1 && c < 8);
            rd_addr = ADDR_W'(200 + k);
            @(negedge pclk);
            n_total++;
            if (rd_ready !== exp_ready[c]) begin
                $display("FAIL rd_pend_ready c=%0d got %b want %b", c, rd_ready, exp_ready[c]);
            end else n_pass++;
            if (rd_req && rd_ready) k++;
            n_total++;
            if (c == 6) begin
                if (mem_we !== 1'b1 || mem_addr !== 17'h01234 || mem_wdata !== 16'hBEEF) begin
                    $display("FAIL rd_pend_write c=%0d we=%b addr=%h data=%h want 1/01234/beef",
                             c, mem_we, mem_addr, mem_wdata);
                end else n_pass++;
            end else begin
                if (mem_we !== 1'b0) begin
                    $display("FAIL rd_pend_we_idle c=%0d mem_we=%b want 0", c, mem_we);
                end else n_pass++;
            end
            n_total++;
            if (rd_valid !== exp_valid[c]) begin
                $display("FAIL rd_pend_valid c=%0d got %b want %b", c, rd_valid, exp_valid[c]);
            end else n_pass++;
            if (exp_valid[c]) begin
                n_total++;
                if (rd_data !== DATA_W'(200 + v)) begin
                    $display("FAIL rd_pend_data c=%0d got %0d want %0d", c, rd_data, 200 + v);
                end else n_pass++;
                v++;
            end
            next_cycle();
        end
        we     = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic test_overflow();
        int wr_cyc [11];
        int wr_src [11];
        int wi;
        wr_cyc = '{6, 11, 16, 21, 22, 23, 24, 25, 26, 27, 28};
        wr_src = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 15};
        wi = 0;
        for (int c = 0; c < 30; c++) begin
            rd_req  = (c < 20);
            rd_addr = 17'd400;
            we      = (c < 20);
            wAddr   = 17'h00300 + ADDR_W'(c);
            wdata   = 16'hC000 + DATA_W'(c);
            clr_ovf = (c == 19);
            @(negedge pclk);
            n_total++;
            if (rd_ready !== (c < 20 && c != 5 && c != 10 && c != 15)) begin
                $display("FAIL ovf_ready c=%0d got %b want %b", c, rd_ready,
                         (c < 20 && c != 5 && c != 10 && c != 15));
            end else n_pass++;
            n_total++;
            if (wr_ovf !== (c >= 10)) begin
                $display("FAIL ovf_flag c=%0d got %b want %b", c, wr_ovf, c >= 10);
            end else n_pass++;
            n_total++;
            if (wi < 11 && c == wr_cyc[wi]) begin
                if (mem_we !== 1'b1 || mem_addr !== 17'h00300 + ADDR_W'(wr_src[wi]) ||
                    mem_wdata !== 16'hC000 + DATA_W'(wr_src[wi])) begin
                    $display("FAIL ovf_write c=%0d we=%b addr=%h data=%h want 1/%h/%h", c,
                             mem_we, mem_addr, mem_wdata, 17'h00300 + wr_src[wi],
                             16'hC000 + wr_src[wi]);
                end else n_pass++;
                wi++;
            end else begin
                if (mem_we !== 1'b0) begin
                    $display("FAIL ovf_we_idle c=%0d mem_we=%b want 0", c, mem_we);
                end else n_pass++;
            end
`ifdef FB_ARB_STATS_EN
            if (c == 15 || c == 19 || c == 20) begin
                n_total++;
                if (drop_cnt !== ((c == 15) ? 16'd5 : (c == 19) ? 16'd8 : 16'd1)) begin
                    $display("FAIL ovf_drop_cnt c=%0d got %0d want %0d", c, drop_cnt,
                             (c == 15) ? 5 : (c == 19) ? 8 : 1);
                end else n_pass++;
            end
`endif
            next_cycle();
        end
        we      = 1'b0;
        rd_req  = 1'b0;
        clr_ovf = 1'b1;
        @(negedge pclk);
        n_total++;
        if (wr_ovf !== 1'b1) begin
            $display("FAIL ovf_before_clr got %b want 1", wr_ovf);
        end else n_pass++;
        next_cycle();
        clr_ovf = 1'b0;
        @(negedge pclk);
        n_total++;
        if (wr_ovf !== 1'b0) begin
            $display("FAIL ovf_after_clr got %b want 0", wr_ovf);
        end else n_pass++;
`ifdef FB_ARB_STATS_EN
        n_total++;
        if (drop_cnt !== 16'd0) begin
            $display("FAIL ovf_cnt_after_clr got %0d want 0", drop_cnt);
        end else n_pass++;
`endif
        next_cycle();
    endtask

    task automatic test_reset_mid_operation();
        for (int c = 0; c < 13; c++) begin
            reset   = (c == 5);
            we      = (c < 5);
            wAddr   = 17'h00500 + ADDR_W'(c);
            wdata   = 16'hD000 + DATA_W'(c);
            rd_req  = (c < 5);
            rd_addr = ADDR_W'(600 + c);
            @(negedge pclk);
            if (c < 5) begin
                n_total++;
                if (rd_ready !== 1'b1) begin
                    $display("FAIL rst_mid_ready c=%0d got %b want 1", c, rd_ready);
                end else n_pass++;
            end
            if (c >= 3 && c <= 5) begin
                n_total++;
                if (rd_valid !== 1'b1 || rd_data !== DATA_W'(600 + c - 3)) begin
                    $display("FAIL rst_mid_pre_data c=%0d valid=%b data=%0d want 1/%0d",
                             c, rd_valid, rd_data, 600 + c - 3);
                end else n_pass++;
            end
            if (c >= 6) begin
                n_total++;
                if (mem_we !== 1'b0 || mem_en !== 1'b0 || rd_valid !== 1'b0) begin
                    $display("FAIL rst_mid_quiet c=%0d mem_we=%b mem_en=%b rd_valid=%b want 0/0/0",
                             c, mem_we, mem_en, rd_valid);
                end else n_pass++;
            end
            if (c == 6) begin
                n_total++;
                if (rd_data !== 16'd0 || dbg_fifo_count !== 4'd0 || dbg_state !== ARB_IDLE) begin
                    $display("FAIL rst_mid_cleared rd_data=%0d count=%0d state=%0d want 0/0/0",
                             rd_data, dbg_fifo_count, dbg_state);
                end else n_pass++;
            end
            next_cycle();
        end
        reset  = 1'b0;
        we     = 1'b0;
        rd_req = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_writes_only();
        idle_cycles(3);
        test_continuous_reads();
        idle_cycles(3);
        test_reads_with_pending_write();
        idle_cycles(3);
        test_overflow();
        idle_cycles(3);
        test_reset_mid_operation();
        idle_cycles(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
